// File: rtl/mmm_nlp_mul_sched.sv
// rtl/mmm_nlp_mul_sched.sv - round-robin, credit-based scheduler sharing one pipelined multiplier among NREQ requesters
// Optional issue/stall statistics counters are built when MMM_SCHED_STATS_EN is defined.
module mmm_nlp_mul_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 256,
   parameter int ODW  = 522,
   parameter int LAT  = 4,
   parameter int FDEP = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NREQ-1:0]         i_req_vld,
   output logic [NREQ-1:0]         o_req_rdy,
   input  logic [NREQ*IDW-1:0]     i_req_a,
   input  logic [NREQ*IDW-1:0]     i_req_b,
   output logic [IDW-1:0]          o_mul_a,
   output logic [IDW-1:0]          o_mul_b,
   output logic                    o_mul_vld,
   input  logic [ODW-1:0]          i_mul_res,
   output logic                    o_res_vld,
   input  logic                    i_res_rdy,
   output logic [ODW-1:0]          o_res,
   output logic [$clog2(NREQ)-1:0] o_res_id,
   output logic                    o_busy,
   output logic [31:0]             o_stat_issue,
   output logic [31:0]             o_stat_stall
);
   localparam int IW  = $clog2(NREQ);
   localparam int AW  = $clog2(FDEP);
   localparam int FCW = $clog2(FDEP + 1);
   localparam int ICW = $clog2(LAT + 1);
   localparam int CW  = $clog2(FDEP + LAT + 1);

   logic [IW-1:0]  ptr;
   logic [IW-1:0]  scan_id;
   logic [IW-1:0]  gnt_id;
   logic           gnt_any;
   logic           credit_ok;
   logic           accept;

   logic [LAT-1:0] tag_vld;
   logic [IW-1:0]  tag_id [LAT];
   logic [ICW-1:0] inflight;

   logic [ODW-1:0] fifo_res [FDEP];
   logic [IW-1:0]  fifo_id [FDEP];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [FCW-1:0] fcnt;
   logic           fifo_full;
   logic           push;
   logic           push_do;
   logic           pop;

   // First valid requester at or after ptr, wrapping.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      scan_id = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan_id = IW'((int'(ptr) + i) % NREQ);
         if (!gnt_any && i_req_vld[scan_id]) begin
            gnt_any = 1'b1;
            gnt_id  = scan_id;
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + ICW'(tag_vld[i]);
      end
   end

   // Credits use registered occupancy only, so a same-cycle pop never frees a slot early.
   assign credit_ok = (CW'(inflight) + CW'(fcnt)) < CW'(FDEP);
   assign accept    = gnt_any & credit_ok & ~i_rst;

   always_comb begin
      o_req_rdy = '0;
      if (accept) begin
         o_req_rdy[gnt_id] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr       <= '0;
         o_mul_vld <= 1'b0;
         o_mul_a   <= '0;
         o_mul_b   <= '0;
         tag_vld   <= '0;
      end else begin
         o_mul_vld  <= accept;
         tag_vld[0] <= accept;
         for (int i = 1; i < LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
         end
         if (accept) begin
            ptr     <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IW'(1);
            o_mul_a <= i_req_a[gnt_id*IDW +: IDW];
            o_mul_b <= i_req_b[gnt_id*IDW +: IDW];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      tag_id[0] <= gnt_id;
      for (int i = 1; i < LAT; i++) begin
         tag_id[i] <= tag_id[i-1];
      end
   end

   assign push      = tag_vld[LAT-1];
   assign fifo_full = (fcnt == FCW'(FDEP));
   assign push_do   = push & ~fifo_full;
   assign pop       = o_res_vld & i_res_rdy;

   always_ff @(posedge i_clk) begin
      if (push_do) begin
         fifo_res[wr_ptr] <= i_mul_res;
         fifo_id[wr_ptr]  <= tag_id[LAT-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
      end else begin
         assert (!(push && fifo_full));
         if (push_do) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_do && !pop) begin
            fcnt <= fcnt + FCW'(1);
         end else if (!push_do && pop) begin
            fcnt <= fcnt - FCW'(1);
         end
      end
   end

   // Head is masked while empty so stale entries never show after reset or drain.
   assign o_res_vld = (fcnt != '0);
   assign o_res     = o_res_vld ? fifo_res[rd_ptr] : '0;
   assign o_res_id  = o_res_vld ? fifo_id[rd_ptr] : '0;
   assign o_busy    = (inflight != '0) | o_res_vld;

`ifdef MMM_SCHED_STATS_EN
   logic stall;
   assign stall = (|i_req_vld) & ~credit_ok;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_stat_issue <= '0;
         o_stat_stall <= '0;
      end else begin
         if (accept && (o_stat_issue != '1)) begin
            o_stat_issue <= o_stat_issue + 32'd1;
         end
         if (stall && (o_stat_stall != '1)) begin
            o_stat_stall <= o_stat_stall + 32'd1;
         end
      end
   end
`else
   assign o_stat_issue = '0;
   assign o_stat_stall = '0;
`endif

endmodule

// File: tb/tb_mmm_nlp_mul_sched.sv
// tb/tb_mmm_nlp_mul_sched.sv - randomized scoreboard bench for mmm_nlp_mul_sched
module tb_mmm_nlp_mul_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 256;
   localparam int ODW  = 522;
   localparam int LAT  = 4;
   localparam int FDEP = 8;
   localparam int IW   = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_vld;
   logic [NREQ-1:0]     req_rdy;
   logic [NREQ*IDW-1:0] req_a;
   logic [NREQ*IDW-1:0] req_b;
   logic [IDW-1:0]      mul_a;
   logic [IDW-1:0]      mul_b;
   logic                mul_vld;
   logic [ODW-1:0]      mul_res;
   logic                res_vld;
   logic                res_rdy;
   logic [ODW-1:0]      res;
   logic [IW-1:0]       res_id;
   logic                busy;
   logic [31:0]         stat_issue;
   logic [31:0]         stat_stall;

   always #5 clk = ~clk;

   mmm_nlp_mul_sched #(.NREQ(NREQ), .IDW(IDW), .ODW(ODW), .LAT(LAT), .FDEP(FDEP)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_vld(req_vld), .o_req_rdy(req_rdy),
      .i_req_a(req_a), .i_req_b(req_b), .o_mul_a(mul_a), .o_mul_b(mul_b),
      .o_mul_vld(mul_vld), .i_mul_res(mul_res), .o_res_vld(res_vld),
      .i_res_rdy(res_rdy), .o_res(res), .o_res_id(res_id), .o_busy(busy),
      .o_stat_issue(stat_issue), .o_stat_stall(stat_stall)
   );

   // Multiplier stand-in: product of the registered operands appears LAT-1 cycles later.
   logic [ODW-1:0] mpipe [LAT-1];
   always @(posedge clk) begin
      mpipe[0] <= ODW'(mul_a) * ODW'(mul_b);
      for (int i = 1; i < LAT-1; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_res = mpipe[LAT-2];

   typedef struct packed {
      logic [IW-1:0]  id;
      logic [ODW-1:0] prod;
      logic [31:0]    t;
   } item_t;

   item_t          mq[$];
   int             cyc, m_ptr, n_cmp, n_err;
   logic           m_mvld, fresh, chk_en;
   logic [IDW-1:0] m_a, m_b;
   int unsigned    m_issue, m_stall;

   logic           d_rst, d_rdy;
   logic [NREQ-1:0] d_vld;
   logic [IDW-1:0] d_a [NREQ];
   logic [IDW-1:0] d_b [NREQ];

   int             acc_ids[$];
   int             acc_cycs[$];
   int             pop_cycs[$];
   logic [ODW-1:0] last_pop_res;

   task automatic check_eq(input string tag, input logic [ODW-1:0] obs, input logic [ODW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [IDW-1:0] rand_op();
      logic [IDW-1:0] v;
      for (int i = 0; i < IDW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic clear_logs();
      acc_ids.delete();
      acc_cycs.delete();
      pop_cycs.delete();
   endtask

   // One clock: apply inputs at negedge, compare against the queue model, then advance the model.
   task automatic step();
      logic [NREQ-1:0] exp_rdy;
      logic            exp_vld;
      int              g;
      item_t           it;
      @(negedge clk);
      rst     = d_rst;
      req_vld = d_vld;
      res_rdy = d_rdy;
      for (int k = 0; k < NREQ; k++) begin
         req_a[k*IDW +: IDW] = d_a[k];
         req_b[k*IDW +: IDW] = d_b[k];
      end
      #1;
      exp_rdy = '0;
      g = -1;
      if (!d_rst && mq.size() < FDEP) begin
         for (int i = 0; i < NREQ; i++) begin
            if (g < 0 && d_vld[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_vld = (mq.size() > 0) && (int'(mq[0].t) <= cyc);

      check_eq("req_rdy", ODW'(req_rdy), ODW'(exp_rdy));
      if (chk_en) begin
         check_eq("res_vld", ODW'(res_vld), ODW'(exp_vld));
         if (exp_vld) begin
            check_eq("res", res, mq[0].prod);
            check_eq("res_id", ODW'(res_id), ODW'(mq[0].id));
         end else if (fresh) begin
            check_eq("res_after_rst", res, '0);
            check_eq("res_id_after_rst", ODW'(res_id), '0);
         end
         check_eq("busy", ODW'(busy), ODW'(mq.size() > 0));
         check_eq("mul_vld", ODW'(mul_vld), ODW'(m_mvld));
         check_eq("mul_a", ODW'(mul_a), ODW'(m_a));
         check_eq("mul_b", ODW'(mul_b), ODW'(m_b));
`ifdef MMM_SCHED_STATS_EN
         check_eq("stat_issue", ODW'(stat_issue), ODW'(m_issue));
         check_eq("stat_stall", ODW'(stat_stall), ODW'(m_stall));
`else
         check_eq("stat_issue_off", ODW'(stat_issue), '0);
         check_eq("stat_stall_off", ODW'(stat_stall), '0);
`endif
      end

      for (int k = 0; k < NREQ; k++) begin
         if (req_vld[k] && req_rdy[k]) begin
            acc_ids.push_back(k);
            acc_cycs.push_back(cyc);
         end
      end
      if (res_vld && res_rdy && !d_rst) begin
         pop_cycs.push_back(cyc);
         last_pop_res = res;
      end

      if (d_rst) begin
         mq.delete();
         m_ptr   = 0;
         m_mvld  = 1'b0;
         m_a     = '0;
         m_b     = '0;
         fresh   = 1'b1;
         m_issue = 0;
         m_stall = 0;
      end else begin
         if (exp_vld) fresh = 1'b0;
         if (exp_vld && d_rdy) void'(mq.pop_front());
         if (g >= 0) begin
            it.id   = IW'(g);
            it.prod = ODW'(d_a[g]) * ODW'(d_b[g]);
            it.t    = 32'(cyc + LAT + 1);
            mq.push_back(it);
            m_ptr   = (g + 1) % NREQ;
            m_mvld  = 1'b1;
            m_a     = d_a[g];
            m_b     = d_b[g];
            m_issue++;
         end else begin
            m_mvld = 1'b0;
            if (d_vld != '0) m_stall++;
         end
      end
      cyc++;
   endtask

   task automatic reset_dut();
      d_rst = 1'b1;
      d_vld = '0;
      step();
      d_rst = 1'b0;
   endtask

   logic [ODW-1:0] maxp;

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; chk_en = 1'b0; fresh = 1'b1;
      m_ptr = 0; m_mvld = 1'b0; m_a = '0; m_b = '0; m_issue = 0; m_stall = 0;
      last_pop_res = '0;
      rst = 1'b1; req_vld = '0; res_rdy = 1'b0; req_a = '0; req_b = '0;
      d_rst = 1'b1; d_vld = '0; d_rdy = 1'b0;
      for (int k = 0; k < NREQ; k++) begin d_a[k] = '0; d_b[k] = '0; end
      step();
      step();
      chk_en = 1'b1;
      d_rst  = 1'b0;

      // Single request
      clear_logs();
      d_a[0] = 256'd3; d_b[0] = 256'd5; d_vld = 4'b0001; d_rdy = 1'b1;
      step();
      d_vld = '0;
      repeat (10) step();
      check_eq("single_pops", ODW'(pop_cycs.size()), ODW'(1));
      check_eq("single_res", last_pop_res, ODW'(15));
      if (pop_cycs.size() > 0 && acc_cycs.size() > 0)
         check_eq("single_lat", ODW'(pop_cycs[0] - acc_cycs[0]), ODW'(LAT + 1));

      // Round-robin fairness from a fresh pointer
      reset_dut();
      clear_logs();
      d_rdy = 1'b1;
      d_vld = '1;
      repeat (12) begin
         for (int k = 0; k < NREQ; k++) begin d_a[k] = rand_op(); d_b[k] = rand_op(); end
         step();
      end
      d_vld = '0;
      repeat (12) step();
      check_eq("rr_count", ODW'(acc_ids.size()), ODW'(12));
      for (int i = 0; i < acc_ids.size() && i < 12; i++)
         check_eq("rr_order", ODW'(acc_ids[i]), ODW'(i % NREQ));
      check_eq("rr_pops", ODW'(pop_cycs.size()), ODW'(12));

      // Backpressure: credits cap accepts at FDEP
      reset_dut();
      clear_logs();
      d_rdy = 1'b0;
      d_vld = '1;
      repeat (20) step();
      check_eq("bp_accepts", ODW'(acc_ids.size()), ODW'(FDEP));
      check_eq("bp_rdy_low", ODW'(req_rdy), '0);
      @(posedge clk);
      #1;
`ifdef MMM_SCHED_STATS_EN
      check_eq("bp_stat_issue", ODW'(stat_issue), ODW'(8));
      check_eq("bp_stat_stall", ODW'(stat_stall), ODW'(12));
`endif
      clear_logs();
      d_rdy = 1'b1;
      repeat (16) step();
      check_eq("bp_resume_seen", ODW'((pop_cycs.size() > 0) && (acc_cycs.size() > 0)), ODW'(1));
      if (pop_cycs.size() > 0 && acc_cycs.size() > 0)
         check_eq("bp_resume_gap", ODW'(acc_cycs[0] - pop_cycs[0]), ODW'(1));
      d_vld = '0;
      repeat (20) step();

      // Maximum operands
      clear_logs();
      d_a[2] = '1; d_b[2] = '1; d_vld = 4'b0100;
      step();
      d_vld = '0;
      repeat (8) step();
      maxp = (ODW'(1) << 512) - (ODW'(1) << 257) + ODW'(1);
      check_eq("max_pops", ODW'(pop_cycs.size()), ODW'(1));
      check_eq("max_res", last_pop_res, maxp);
      check_eq("max_upper", ODW'(last_pop_res[ODW-1:512]), '0);

      // Reset with 3 in flight and 2 queued
      clear_logs();
      d_rdy = 1'b0;
      d_vld = 4'b1000;
      repeat (5) begin
         d_a[3] = rand_op(); d_b[3] = rand_op();
         step();
      end
      d_vld = '0;
      step();
      check_eq("mid_accepts", ODW'(acc_ids.size()), ODW'(5));
      d_rst = 1'b1;
      d_vld = '1;
      step();
      check_eq("mid_rst_rdy", ODW'(req_rdy), '0);
      d_rst = 1'b0;
      clear_logs();
      step();
      check_eq("post_rst_res_vld", ODW'(res_vld), '0);
      check_eq("post_rst_busy", ODW'(busy), '0);
      check_eq("post_rst_mul_vld", ODW'(mul_vld), '0);
      check_eq("post_rst_mul_a", ODW'(mul_a), '0);
      check_eq("post_rst_res", res, '0);
      check_eq("post_rst_grant", ODW'((acc_ids.size() > 0) ? acc_ids[0] : -1), ODW'(0));
      d_vld = '0;
      d_rdy = 1'b1;
      repeat (12) step();
      check_eq("post_rst_pops", ODW'(pop_cycs.size()), ODW'(1));

      // Randomized traffic with occasional resets
      repeat (400) begin
         d_vld = NREQ'($urandom);
         for (int k = 0; k < NREQ; k++) begin d_a[k] = rand_op(); d_b[k] = rand_op(); end
         d_rdy = ($urandom_range(0, 9) < 7);
         d_rst = ($urandom_range(0, 99) == 0);
         step();
      end
      d_rst = 1'b0;
      d_vld = '0;
      d_rdy = 1'b1;
      repeat (20) step();
      check_eq("drain_res_vld", ODW'(res_vld), '0);
      check_eq("drain_busy", ODW'(busy), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
